pe_dbw: RTL and testbench

- Second-generation systolic-array processing element. Fully parametrised in data width and fixed-point format.
- Weight-stationary MAC with a double-buffered weight register. Adds, compared with the first-generation PE:
  - a shadow-weight full flag, and a switch-without-load error flag;
  - round-half-up product rounding;
  - saturation, with a saturation flag;
  - an accumulate mode for output-stationary dataflow, with a drain command.
- Tiles N×M inside the array: north/south carry psum, weight and weight-accept; west/east carry input, valid, switch and drain.

---
 rtl/pe_pkg.sv | 37 +++
 rtl/pe_mac_q.sv | 48 ++++
 rtl/pe_dbw.sv | 143 ++++++++++++++
 tb/tb_pe_dbw.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Q-format constants and helpers shared by the second-generation systolic PE.
// to_q is a bench-side convenience and is not used by the datapath.
package pe_pkg;
   localparam int DW        = 16;
   localparam int FRAC_BITS = 8;

   typedef struct packed {
      logic [DW-1:0] val;
      logic          sat;
   } sat_res_t;

   function automatic logic [DW-1:0] to_q(input real x);
      real scaled;
      scaled = x * real'(1 << FRAC_BITS);
      return DW'($rtoi(scaled));
   endfunction

   // Clamp a 2*DW+1 bit signed sum into DW bits and flag out-of-range values.
   function automatic sat_res_t sat_trunc(input logic signed [2*DW:0] s);
      sat_res_t             r;
      logic signed [2*DW:0] max_v;
      logic signed [2*DW:0] min_v;
      max_v = $signed({{(DW+2){1'b0}}, {(DW-1){1'b1}}});
      min_v = $signed({{(DW+2){1'b1}}, {(DW-1){1'b0}}});
      if (s > max_v) begin
         r.val = {1'b0, {(DW-1){1'b1}}};
         r.sat = 1'b1;
      end else if (s < min_v) begin
         r.val = {1'b1, {(DW-1){1'b0}}};
         r.sat = 1'b1;
      end else begin
         r.val = s[DW-1:0];
         r.sat = 1'b0;
      end
      return r;
   endfunction
endpackage

// File: rtl/pe_mac_q.sv
// Combinational fixed-point MAC: multiply, optional round-half-up, shift,
// add a DW-bit addend, then clamp or wrap back to DW bits.
module pe_mac_q
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = DW,
   parameter int FRAC       = FRAC_BITS,
   parameter int ROUND_EN   = 1,
   parameter int SAT_EN     = 1
) (
   input  logic signed [DATA_WIDTH-1:0] i_a,
   input  logic signed [DATA_WIDTH-1:0] i_w,
   input  logic signed [DATA_WIDTH-1:0] i_addend,
   output logic        [DATA_WIDTH-1:0] o_res,
   output logic                         o_sat
);
   localparam int PW = 2 * DATA_WIDTH;
   localparam logic signed [PW-1:0] RND_K = (ROUND_EN != 0) ? (PW'(1) << (FRAC - 1)) : PW'(0);
   localparam logic signed [PW:0] MAX_S = $signed({{(PW-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
   localparam logic signed [PW:0] MIN_S = $signed({{(PW-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}});

   logic signed [PW-1:0] w_prod;
   logic signed [PW-1:0] w_rnd;
   logic signed [PW-1:0] w_shift;
   logic signed [PW:0]   w_sum;
   logic                 w_over;
   logic                 w_under;

   assign w_prod  = $signed({{DATA_WIDTH{i_a[DATA_WIDTH-1]}}, i_a})
                  * $signed({{DATA_WIDTH{i_w[DATA_WIDTH-1]}}, i_w});
   assign w_rnd   = w_prod + RND_K;
   assign w_shift = w_rnd >>> FRAC;
   assign w_sum   = {w_shift[PW-1], w_shift}
                  + {{(PW-DATA_WIDTH+1){i_addend[DATA_WIDTH-1]}}, i_addend};
   assign w_over  = (w_sum > MAX_S);
   assign w_under = (w_sum < MIN_S);
   assign o_sat   = w_over | w_under;

   always_comb begin
      o_res = w_sum[DATA_WIDTH-1:0];
      if (SAT_EN != 0) begin
         if (w_over)
            o_res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
         else if (w_under)
            o_res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end
   end
endmodule

// File: rtl/pe_dbw.sv
// Weight-stationary systolic PE with double-buffered weights, saturation and
// an output-stationary accumulate mode drained on command.
module pe_dbw #(
   parameter int DATA_WIDTH = pe_pkg::DW,
   parameter int FRAC_BITS  = pe_pkg::FRAC_BITS,
   parameter int ROUND_EN   = 1,
   parameter int SAT_EN     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pe_enabled,
   input  logic                  pe_acc_mode,
   input  logic [DATA_WIDTH-1:0] pe_psum_in,
   input  logic [DATA_WIDTH-1:0] pe_weight_in,
   input  logic                  pe_accept_w_in,
   input  logic [DATA_WIDTH-1:0] pe_input_in,
   input  logic                  pe_valid_in,
   input  logic                  pe_switch_in,
   input  logic                  pe_drain_in,
   output logic [DATA_WIDTH-1:0] pe_psum_out,
   output logic [DATA_WIDTH-1:0] pe_weight_out,
   output logic                  pe_accept_w_out,
   output logic [DATA_WIDTH-1:0] pe_input_out,
   output logic                  pe_valid_out,
   output logic                  pe_switch_out,
   output logic                  pe_drain_out,
   output logic                  pe_sat_out,
   output logic                  pe_sw_err
);
   import pe_pkg::*;

   logic [DATA_WIDTH-1:0] r_w_active;
   logic [DATA_WIDTH-1:0] r_w_shadow;
   logic                  r_shadow_full;
   logic [DATA_WIDTH-1:0] r_acc;
   logic                  r_acc_sat;
   logic [DATA_WIDTH-1:0] r_psum;
   logic [DATA_WIDTH-1:0] r_weight;
   logic                  r_accept;
   logic [DATA_WIDTH-1:0] r_input;
   logic                  r_valid;
   logic                  r_switch;
   logic                  r_drain;
   logic                  r_sat;
   logic                  r_sw_err;

   logic [DATA_WIDTH-1:0] w_addend;
   logic [DATA_WIDTH-1:0] w_res;
   logic                  w_sat;

   assign w_addend = pe_acc_mode ? r_acc : pe_psum_in;

   pe_mac_q #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC       (FRAC_BITS),
      .ROUND_EN   (ROUND_EN),
      .SAT_EN     (SAT_EN)
   ) u_mac (
      .i_a      (pe_input_in),
      .i_w      (r_w_active),
      .i_addend (w_addend),
      .o_res    (w_res),
      .o_sat    (w_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_w_active    <= '0;
         r_w_shadow    <= '0;
         r_shadow_full <= 1'b0;
         r_acc         <= '0;
         r_acc_sat     <= 1'b0;
         r_psum        <= '0;
         r_weight      <= '0;
         r_accept      <= 1'b0;
         r_input       <= '0;
         r_valid       <= 1'b0;
         r_switch      <= 1'b0;
         r_drain       <= 1'b0;
         r_sat         <= 1'b0;
         r_sw_err      <= 1'b0;
      end else if (!pe_enabled) begin
         r_valid  <= 1'b0;
         r_switch <= 1'b0;
         r_drain  <= 1'b0;
         r_sat    <= 1'b0;
      end else begin
         r_weight <= pe_weight_in;
         r_accept <= pe_accept_w_in;
         r_input  <= pe_input_in;
         r_switch <= pe_switch_in;
         r_drain  <= pe_drain_in;

         // Promotion reads the old shadow, so a same-cycle load lands behind it.
         if (pe_switch_in) begin
            if (r_shadow_full) begin
               r_w_active    <= r_w_shadow;
               r_shadow_full <= 1'b0;
            end else begin
               r_sw_err <= 1'b1;
            end
         end
         if (pe_accept_w_in) begin
            r_w_shadow    <= pe_weight_in;
            r_shadow_full <= 1'b1;
         end

         if (!pe_acc_mode) begin
            r_valid <= pe_valid_in;
            r_sat   <= pe_valid_in & w_sat;
            if (pe_valid_in)
               r_psum <= w_res;
         end else begin
            r_valid <= pe_drain_in;
            r_sat   <= 1'b0;
            if (pe_drain_in) begin
               r_acc     <= '0;
               r_acc_sat <= 1'b0;
               if (pe_valid_in) begin
                  r_psum <= w_res;
                  r_sat  <= w_sat | r_acc_sat;
               end else begin
                  r_psum <= r_acc;
                  r_sat  <= r_acc_sat;
               end
            end else if (pe_valid_in) begin
               r_acc     <= w_res;
               r_acc_sat <= r_acc_sat | w_sat;
            end
         end
      end
   end

   assign pe_psum_out     = r_psum;
   assign pe_weight_out   = r_weight;
   assign pe_accept_w_out = r_accept;
   assign pe_input_out    = r_input;
   assign pe_valid_out    = r_valid;
   assign pe_switch_out   = r_switch;
   assign pe_drain_out    = r_drain;
   assign pe_sat_out      = r_sat;
   assign pe_sw_err       = r_sw_err;
endmodule

// File: tb/tb_pe_dbw.sv
// Directed bench for pe_dbw: default, truncating and wrapping instances share
// one stimulus stream so each format variant is checked against the same beats.
module tb_pe_dbw;
   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        acc_mode;
   logic [15:0] psum_in;
   logic [15:0] weight_in;
   logic        accept_in;
   logic [15:0] input_in;
   logic        valid_in;
   logic        switch_in;
   logic        drain_in;

   logic [15:0] d_psum, d_weight, d_input;
   logic        d_accept, d_valid, d_switch, d_drain, d_sat, d_err;
   logic [15:0] r_psum, r_weight, r_input;
   logic        r_accept, r_valid, r_switch, r_drain, r_sat, r_err;
   logic [15:0] s_psum, s_weight, s_input;
   logic        s_accept, s_valid, s_switch, s_drain, s_sat, s_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pe_dbw #(.DATA_WIDTH(16), .FRAC_BITS(8), .ROUND_EN(1), .SAT_EN(1)) u_dut (
      .clk(clk), .rst(rst), .pe_enabled(en), .pe_acc_mode(acc_mode),
      .pe_psum_in(psum_in), .pe_weight_in(weight_in), .pe_accept_w_in(accept_in),
      .pe_input_in(input_in), .pe_valid_in(valid_in), .pe_switch_in(switch_in),
      .pe_drain_in(drain_in), .pe_psum_out(d_psum), .pe_weight_out(d_weight),
      .pe_accept_w_out(d_accept), .pe_input_out(d_input), .pe_valid_out(d_valid),
      .pe_switch_out(d_switch), .pe_drain_out(d_drain), .pe_sat_out(d_sat),
      .pe_sw_err(d_err));

   pe_dbw #(.DATA_WIDTH(16), .FRAC_BITS(8), .ROUND_EN(0), .SAT_EN(1)) u_nr (
      .clk(clk), .rst(rst), .pe_enabled(en), .pe_acc_mode(acc_mode),
      .pe_psum_in(psum_in), .pe_weight_in(weight_in), .pe_accept_w_in(accept_in),
      .pe_input_in(input_in), .pe_valid_in(valid_in), .pe_switch_in(switch_in),
      .pe_drain_in(drain_in), .pe_psum_out(r_psum), .pe_weight_out(r_weight),
      .pe_accept_w_out(r_accept), .pe_input_out(r_input), .pe_valid_out(r_valid),
      .pe_switch_out(r_switch), .pe_drain_out(r_drain), .pe_sat_out(r_sat),
      .pe_sw_err(r_err));

   pe_dbw #(.DATA_WIDTH(16), .FRAC_BITS(8), .ROUND_EN(1), .SAT_EN(0)) u_ns (
      .clk(clk), .rst(rst), .pe_enabled(en), .pe_acc_mode(acc_mode),
      .pe_psum_in(psum_in), .pe_weight_in(weight_in), .pe_accept_w_in(accept_in),
      .pe_input_in(input_in), .pe_valid_in(valid_in), .pe_switch_in(switch_in),
      .pe_drain_in(drain_in), .pe_psum_out(s_psum), .pe_weight_out(s_weight),
      .pe_accept_w_out(s_accept), .pe_input_out(s_input), .pe_valid_out(s_valid),
      .pe_switch_out(s_switch), .pe_drain_out(s_drain), .pe_sat_out(s_sat),
      .pe_sw_err(s_err));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      accept_in = 1'b0; switch_in = 1'b0; valid_in = 1'b0; drain_in = 1'b0;
   endtask

   task automatic load_switch(input logic [15:0] w);
      idle(); accept_in = 1'b1; weight_in = w;
      step();
      idle(); switch_in = 1'b1;
      step();
      idle();
   endtask

   task automatic beat(input logic [15:0] a, input logic [15:0] p);
      idle(); valid_in = 1'b1; input_in = a; psum_in = p;
      step();
      idle();
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; acc_mode = 1'b0;
      psum_in = '0; weight_in = '0; input_in = '0;
      idle();
      step(); step();
      chk("rst_psum",  d_psum,  32'h0);
      chk("rst_valid", d_valid, 32'h0);
      chk("rst_sat",   d_sat,   32'h0);
      chk("rst_err",   d_err,   32'h0);
      rst = 1'b0;

      // basic MAC and forwarding
      accept_in = 1'b1; weight_in = 16'h0200;
      step();
      chk("fwd_accept", d_accept, 32'h1);
      chk("fwd_weight", d_weight, 32'h0200);
      idle(); switch_in = 1'b1;
      step();
      chk("fwd_switch", d_switch, 32'h1);
      chk("pre_valid",  d_valid,  32'h0);
      beat(16'h0300, 16'h0100);
      chk("basic_psum",  d_psum,  32'h0700);
      chk("basic_valid", d_valid, 32'h1);
      chk("basic_sat",   d_sat,   32'h0);
      chk("fwd_input",   d_input, 32'h0300);
      step();
      chk("idle_valid", d_valid, 32'h0);
      chk("idle_hold",  d_psum,  32'h0700);

      // rounding
      load_switch(16'h0001);
      beat(16'h0080, 16'h0000);
      chk("round_on",  d_psum, 32'h0001);
      chk("round_off", r_psum, 32'h0000);

      // saturation
      load_switch(16'h6400);
      beat(16'h6400, 16'h0000);
      chk("sat_pos",      d_psum, 32'h7FFF);
      chk("sat_pos_flag", d_sat,  32'h1);
      chk("wrap_pos",     s_psum, 32'h1000);
      beat(16'h9C00, 16'h0000);
      chk("sat_neg",      d_psum, 32'h8000);
      chk("sat_neg_flag", d_sat,  32'h1);
      chk("wrap_neg",     s_psum, 32'hF000);
      step();
      chk("sat_pulse", d_sat, 32'h0);

      // switch rules
      switch_in = 1'b1;
      step();
      idle();
      chk("sw_err_set", d_err, 32'h1);
      beat(16'h0001, 16'h0000);
      chk("sw_old_w", d_psum, 32'h0064);
      accept_in = 1'b1; weight_in = 16'h0100;
      step();
      accept_in = 1'b1; weight_in = 16'h0300; switch_in = 1'b1;
      step();
      idle();
      beat(16'h0200, 16'h0000);
      chk("sw_ld_first", d_psum, 32'h0200);
      switch_in = 1'b1;
      step();
      idle();
      beat(16'h0200, 16'h0000);
      chk("sw_ld_second", d_psum, 32'h0600);
      chk("sw_err_sticky", d_err, 32'h1);

      // accumulate mode
      load_switch(16'h0180);
      acc_mode = 1'b1;
      beat(16'h0100, 16'h1234);
      chk("acc_valid0", d_valid, 32'h0);
      beat(16'h0200, 16'h1234);
      beat(16'h0300, 16'h1234);
      chk("acc_valid2", d_valid, 32'h0);
      drain_in = 1'b1;
      step();
      chk("drain_psum",  d_psum,  32'h0900);
      chk("drain_valid", d_valid, 32'h1);
      chk("drain_sat",   d_sat,   32'h0);
      chk("fwd_drain",   d_drain, 32'h1);
      step();
      chk("drain2_psum",  d_psum,  32'h0000);
      chk("drain2_valid", d_valid, 32'h1);
      idle();
      step();
      chk("drain_done", d_valid, 32'h0);
      beat(16'h0100, 16'h0000);
      valid_in = 1'b1; drain_in = 1'b1; input_in = 16'h0200;
      step();
      idle();
      chk("drain_mac_psum", d_psum, 32'h0480);
      drain_in = 1'b1;
      step();
      idle();
      chk("drain_mac_clr", d_psum, 32'h0000);

      // enable and reset
      acc_mode = 1'b0;
      beat(16'h0200, 16'h0010);
      chk("en_base", d_psum, 32'h0310);
      en = 1'b0;
      beat(16'h0400, 16'h0000);
      chk("dis_hold",  d_psum,  32'h0310);
      chk("dis_valid", d_valid, 32'h0);
      chk("dis_input", d_input, 32'h0200);
      en = 1'b1;
      beat(16'h0100, 16'h0000);
      chk("en_resume", d_psum, 32'h0180);
      rst = 1'b1;
      beat(16'h0200, 16'h0000);
      rst = 1'b0;
      chk("rstmid_psum",  d_psum,  32'h0);
      chk("rstmid_valid", d_valid, 32'h0);
      chk("rstmid_input", d_input, 32'h0);
      chk("rstmid_err",   d_err,   32'h0);
      beat(16'h0100, 16'h0042);
      chk("rst_w_zero", d_psum, 32'h0042);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
